// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states, step count.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef logic [1:0] muldiv_state_e;
  localparam muldiv_state_e ST_IDLE = 2'd0;
  localparam muldiv_state_e ST_CALC = 2'd1;
  localparam muldiv_state_e ST_DONE = 2'd2;

  localparam int MULDIV_STEPS = 32;

endpackage

// File: rtl/ex_div_core.sv
// Restoring shift-subtract divider step datapath on operand magnitudes, one quotient bit per step.
module ex_div_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quo_nxt_o,
  output logic [DATA_WIDTH-1:0] rem_nxt_o
);

  localparam int RW = DATA_WIDTH + 1;

  logic [RW-1:0]         rem_q;
  logic [RW-1:0]         rem_d;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic [RW:0]           rem_sh;
  logic                  fits;

  // Shift the next dividend bit into the partial remainder and try the subtraction.
  assign rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
  assign fits      = (rem_sh >= {2'b00, div_q});
  assign rem_d     = fits ? RW'(rem_sh - {2'b00, div_q}) : rem_sh[RW-1:0];
  assign quo_nxt_o = {quo_q[DATA_WIDTH-2:0], fits};
  assign rem_nxt_o = rem_d[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      div_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide unit with IDLE/CALC/DONE control.
// Define MULDIV_FAST_MUL_EN to complete multiplies combinationally at accept.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  muldiv_op_e            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int                    PW       = 2 * DATA_WIDTH;
  localparam int                    CNT_W    = $clog2(MULDIV_STEPS);
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(MULDIV_STEPS - 1);
  localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [PW-1:0] cond_neg_wide(input logic [PW-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  muldiv_state_e         state_q;
  logic [CNT_W-1:0]      cnt_q;
  muldiv_op_e            op_q;
  logic                  a_neg_q;
  logic                  b_neg_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [PW-1:0]         acc_q;

  logic                  a_signed_op;
  logic                  b_signed_op;
  logic                  a_sgn;
  logic                  b_sgn;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_res;
  logic                  accept;
  logic                  div_step;
  logic [DATA_WIDTH:0]   mul_sum;
  logic [PW-1:0]         acc_nxt;
  logic [PW-1:0]         prod_fix;
  logic [DATA_WIDTH-1:0] quo_nxt;
  logic [DATA_WIDTH-1:0] rem_nxt;
  logic [DATA_WIDTH-1:0] calc_res;

  // Issue stage: operand signedness, magnitudes and the RISC-V special cases.
  always_comb begin
    a_signed_op = 1'b0;
    b_signed_op = 1'b0;
    case (op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_op = 1'b1;
        b_signed_op = 1'b1;
      end
      OP_MULHSU: a_signed_op = 1'b1;
      default: ;
    endcase
  end

  assign a_sgn  = a_signed_op & rs1_i[DATA_WIDTH-1];
  assign b_sgn  = b_signed_op & rs2_i[DATA_WIDTH-1];
  assign a_mag  = cond_neg(rs1_i, a_sgn);
  assign b_mag  = cond_neg(rs2_i, b_sgn);
  assign accept = (state_q == ST_IDLE) & valid_i & ~flush_i;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [PW-1:0] fa_s;
  logic signed [PW-1:0] fb_s;
  logic        [PW-1:0] fast_prod;

  assign fa_s      = {{DATA_WIDTH{a_sgn}}, rs1_i};
  assign fb_s      = {{DATA_WIDTH{b_sgn}}, rs2_i};
  assign fast_prod = fa_s * fb_s;
`endif

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op_i[2]) begin
      if (rs2_i == '0) begin
        special     = 1'b1;
        special_res = op_i[1] ? rs1_i : '1;
      end else if (!op_i[0] && rs1_i == INT_MIN && rs2_i == '1) begin
        special     = 1'b1;
        special_res = op_i[1] ? '0 : INT_MIN;
      end
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      special     = 1'b1;
      special_res = (op_i == OP_MUL) ? fast_prod[DATA_WIDTH-1:0] : fast_prod[PW-1:DATA_WIDTH];
`endif
    end
  end

  // Iteration stage: shift-add multiplier step and divider core.
  assign mul_sum  = {1'b0, acc_q[PW-1:DATA_WIDTH]} + {1'b0, mcand_q & {DATA_WIDTH{acc_q[0]}}};
  assign acc_nxt  = {mul_sum, acc_q[DATA_WIDTH-1:1]};
  assign div_step = (state_q == ST_CALC) & ~flush_i & op_q[2];

  ex_div_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Completion stage: sign correction and word select, taken from the final step's values.
  always_comb begin
    prod_fix = cond_neg_wide(acc_nxt, a_neg_q ^ b_neg_q);
    case (op_q)
      OP_MUL:                       calc_res = prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[PW-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              calc_res = cond_neg(quo_nxt, a_neg_q ^ b_neg_q);
      default:                      calc_res = cond_neg(rem_nxt, a_neg_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_q    <= op_i;
            a_neg_q <= a_sgn;
            b_neg_q <= b_sgn;
            mcand_q <= a_mag;
            acc_q   <= {{DATA_WIDTH{1'b0}}, b_mag};
            if (special) begin
              result_o <= special_res;
              state_q  <= ST_DONE;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!op_q[2]) acc_q <= acc_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_o <= calc_res;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == ST_CALC) | accept;
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: scoreboarded results, latency, flush and async reset.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  muldiv_op_e  op_i    = OP_MUL;
  logic [31:0] rs1_i   = '0;
  logic [31:0] rs2_i   = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Called just after a falling edge with the unit idle; returns likewise.
  task automatic run_op(input string tag, input muldiv_op_e op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    exp_t e;
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   got = 1'b0;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    valid_i = 1'b1;
    e.tag = tag;
    e.res = exp;
    e.lat = lat;
    sb.push_back(e);
    #1;
    if (busy_o) busy_cnt++;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({e.tag, " result"}, result_o, e.res);
        chk({e.tag, " latency"}, cyc, e.lat);
        chk({e.tag, " busy cycles"}, busy_cnt, (e.lat == 1) ? 1 : 33);
      end
    end
    valid_i = 1'b0;
    if (!got) begin
      total++;
      $error("FAIL %s timeout: no done_o within %0d cycles, required %0d", tag, cyc, lat);
      sb.delete();
    end
    @(negedge clk);
    chk({tag, " done pulse ends"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div -20/3",       OP_DIV,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33);
    run_op("rem -20/3",       OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);
    run_op("div 20/-3",       OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    run_op("rem 20/-3",       OP_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         33);
    run_op("divu max/2",      OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
    run_op("remu max/2",      OP_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         33);
    run_op("divu 100/0",      OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu 100/0",      OP_REMU, 32'd100,       32'd0,         32'h64,        1);
    run_op("rem -7/0",        OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
    run_op("div ovf",         OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",         OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("mulh min*min",    OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu max*max",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mul 7*-3",        OP_MUL,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhsu -1*max",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

    // Flush a DIVU in its tenth CALC cycle; result_o keeps the MULHSU value.
    op_i    = OP_DIVU;
    rs1_i   = 32'd1000;
    rs2_i   = 32'd7;
    valid_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("flush pre busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush done", 32'(done_o), 32'd0);
    chk("flush result held", result_o, 32'hFFFF_FFFF);
    run_op("divu after flush", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33);
    run_op("remu 1000/7",      OP_REMU, 32'd1000, 32'd7, 32'd6,   33);

    // Asynchronous reset in the middle of CALC.
    op_i    = OP_DIV;
    rs1_i   = 32'hFFFF_FFEC;
    rs2_i   = 32'd3;
    valid_i = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("async rst busy", 32'(busy_o), 32'd0);
    chk("async rst done", 32'(done_o), 32'd0);
    chk("async rst result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post rst busy", 32'(busy_o), 32'd0);
    chk("post rst done", 32'(done_o), 32'd0);
    chk("post rst result", result_o, 32'd0);
    run_op("div after reset", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the RV32M extension. It lives in the EX stage and consumes operands and the M-op code from the ID/EX pipeline register. It stalls the front of the pipeline while a multi-cycle operation runs and returns one registered result, with a one-cycle `done_o` pulse, before the EX/MEM register captures it.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1: pipeline clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush_i`  in  1: abort the in-flight operation (branch mispredict or trap).
- `valid_i`  in  1: EX holds an M-extension instruction; level-held until it retires.
- `op_i`  in  `muldiv_op_e` (3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 encoding).
- `rs1_i`  in  `DATA_WIDTH`: forwarded operand A (dividend or multiplicand).
- `rs2_i`  in  `DATA_WIDTH`: forwarded operand B (divisor or multiplier).
- `busy_o`  out  1: stall request to the hazard unit.
- `done_o`  out  1: one-cycle pulse; `result_o` is valid this cycle.
- `result_o`  out  `DATA_WIDTH`: registered result. Holds its value until the next completion.

## Operation
- The FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE with `valid_i`=1 and `flush_i`=0 accepts the operation at the next edge.
  - The unit latches `op_i`, the operand magnitudes and the sign flags.
  - A special case goes directly to DONE. Otherwise the FSM enters CALC with the step counter at 31.
- CALC runs one step per cycle and decrements the counter. After the step with counter 0 the FSM goes to DONE.
  - Division uses restoring shift-subtract: a 33-bit remainder and a 32-bit quotient register.
  - Multiplication uses shift-add into a 64-bit accumulator.
- In DONE:
  - Apply sign correction: negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative.
  - Select the low or high product word by `op_i`.
  - Assert `done_o` and write `result_o`. The next state is always IDLE.
  - `valid_i` is ignored in DONE, so the retiring instruction is never re-issued.
- Signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats `rs1` as signed and `rs2` as unsigned. MULHU and DIVU/REMU treat both as unsigned.
- Special cases skip CALC. These are fixed by the RISC-V spec:
  - Divide by zero: DIV/DIVU give 0xFFFF_FFFF. REM/REMU give `rs1`.
  - Signed overflow (DIV with 0x8000_0000 / 0xFFFF_FFFF): quotient 0x8000_0000, remainder 0.
- `busy_o` = (state==CALC) | (state==IDLE & `valid_i` & !`flush_i`). The stall is asserted in the issue cycle and is combinational. `busy_o` is low in DONE, so the pipeline advances at the end of DONE.
- `flush_i`=1 in any state: the FSM goes to IDLE at the next edge. There is no `done_o` pulse and `result_o` is unchanged.
- Reset, including reset mid-operation: state IDLE, `busy_o`=0 once `valid_i` is low, `done_o`=0, `result_o`=0, counter 0, and all datapath registers cleared.

## Timing
- Accept edge is t0.
  - Iterative path: CALC occupies the 32 cycles after t0, and `done_o` is high in cycle 33.
  - Special-case path: `done_o` is high in cycle 1.
- `result_o` updates only at the edge that enters DONE and is stable for the whole DONE cycle.
- Back-to-back M ops: the next accept can happen no earlier than the edge after DONE, i.e. the following IDLE cycle.
- `flush_i` has priority over `valid_i`, over counter expiry and over entry to DONE when they occur in the same cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU compute a 64-bit signed-extended product combinationally at accept. They go directly to DONE, so `done_o` comes in cycle 1.
- `MULDIV_FAST_MUL_EN` undefined: multiplies use the 32-cycle shift-add path. Divide timing is unchanged either way.

## Structure
- The shared `defines` package holds:
  - `muldiv_op_e` (3-bit, funct3 values).
  - `muldiv_state_e` (IDLE/CALC/DONE).
  - `MULDIV_STEPS` = 32.
- One sub-module, `ex_div_core`, implements the restoring-division step datapath: remainder/quotient registers and a one-bit-per-cycle step enable. The FSM, sign handling, multiplier and special cases stay in `ex_muldiv_unit`.

## Test plan
- DIV -20 / 3 (0xFFFF_FFEC, 0x3) → `busy_o` high for 33 cycles. `done_o` in cycle 33 with `result_o`=0xFFFF_FFFA. REM on the same operands gives 0xFFFF_FFFE.
- DIVU 100 / 0 → `done_o` in cycle 1 with `result_o`=0xFFFF_FFFF. REMU 100 / 0 gives 0x64.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM on the same operands gives 0.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MUL 7 × -3 → 0xFFFF_FFEB. Latency is 33 cycles without the macro and 1 cycle with it.
- Start DIVU 1000 / 7, assert `flush_i` in CALC cycle 10 → IDLE next cycle, no `done_o`, `result_o` keeps its prior value. A new op accepted immediately afterwards completes correctly.
- Drop `rst_n` asynchronously mid-CALC → all outputs 0 immediately. After release with `valid_i`=0: IDLE and `busy_o`=0.
